// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buffer
//  Description : Writer side of the ADC sample buffer. Captures
//                {adc_a_d, adc_b_d} into a circular RAM with pretrigger,
//                level/edge trigger on channel A and power-of-two decimation.
//                Exposes a trigger-relative read port for the SPI side.
//                Optional auto-trigger timeout: define CAPTURE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_buffer #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger_mcu,
    input  logic [7:0]        adc_a_d,
    input  logic [7:0]        adc_b_d,
    input  logic [31:0]       cfg,
    output logic              ready_mcu,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              timed_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic                   w_arm;
    logic [15:0]            r_dec_cnt;
    logic [15:0]            w_dec_mask;
    logic                   w_strobe;
    logic                   w_busy;
    logic                   w_we;
    logic                   w_edge_hit;
    logic                   w_to_hit;
    logic                   w_trig;
    logic [ADDR_W-1:0]      w_post_init;

    // Configuration fields latched on arm
    logic [7:0]             r_level;
    logic                   r_slope;
    logic                   r_force;
    logic [3:0]             r_decim;
    logic [ADDR_W-1:0]      r_pretrig;

    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_pre_cnt;
    logic [ADDR_W-1:0]      r_post_rem;
    logic [ADDR_W-1:0]      r_start_addr;
    logic [ADDR_W-1:0]      r_trig_addr;
    logic [7:0]             r_prev;
    logic                   r_p_valid;
    logic                   r_timed_out;
    logic [DATA_W-1:0]      r_rd_data;
    logic [DATA_W-1:0]      r_mem [0:(1<<ADDR_W)-1];

    // Reserved cfg bits are intentionally ignored
    logic w_unused_cfg;
    assign w_unused_cfg = ^cfg[19:14];

    // Arm-request synchroniser plus rising-edge detector on its output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_q <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], trigger_mcu};
            r_sync_q <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_arm       = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_dec_mask  = (16'd1 << r_decim) - 16'd1;
    assign w_strobe    = ((r_dec_cnt & w_dec_mask) == 16'd0);
    assign w_busy      = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    // Arm takes priority over any write/trigger in the same cycle
    assign w_we        = w_strobe & w_busy & ~w_arm;
    // Remaining post writes after the trigger sample: depth - pretrig - 1
    assign w_post_init = ~r_pretrig;
    assign w_edge_hit  = r_p_valid &
                         (r_slope ? ((r_prev > r_level) && (adc_a_d <= r_level))
                                  : ((r_prev < r_level) && (adc_a_d >= r_level)));
    assign w_trig      = w_we & (r_state == S_ARMED) & (r_force | w_edge_hit | w_to_hit);

`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [23:0] c_to_last = 24'hFF_FFFE;
    logic [23:0] r_to_cnt;

    // Counts ARMED strobes; the strobe that brings the count to 2^24-1 auto-triggers
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_to_cnt <= 24'd0;
        end else if (w_we && (r_state == S_ARMED) && !w_trig) begin
            r_to_cnt <= r_to_cnt + 24'd1;
        end
    end

    assign w_to_hit = (r_to_cnt == c_to_last);
`else
    assign w_to_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_arm) begin
            w_state_nxt = (cfg[31:20] == 12'd0) ? S_ARMED : S_PRE;
        end else if (w_we) begin
            case (r_state)
                S_PRE:   if (r_pre_cnt == r_pretrig - 1'b1) w_state_nxt = S_ARMED;
                S_ARMED: if (w_trig) w_state_nxt = (w_post_init == '0) ? S_DONE : S_POST;
                S_POST:  if (r_post_rem == {{(ADDR_W-1){1'b0}}, 1'b1}) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Capture bookkeeping: config latch, decimation, pointers, trigger history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_cnt    <= 16'd0;
            r_level      <= 8'd0;
            r_slope      <= 1'b0;
            r_force      <= 1'b0;
            r_decim      <= 4'd0;
            r_pretrig    <= '0;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_rem   <= '0;
            r_start_addr <= '0;
            r_trig_addr  <= '0;
            r_prev       <= 8'd0;
            r_p_valid    <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            r_dec_cnt <= w_arm ? 16'd0 : r_dec_cnt + 16'd1;
            if (w_arm) begin
                r_level     <= cfg[7:0];
                r_slope     <= cfg[8];
                r_force     <= cfg[9];
                r_decim     <= cfg[13:10];
                r_pretrig   <= ADDR_W'(cfg[31:20]);
                r_pre_cnt   <= '0;
                r_p_valid   <= 1'b0;
                r_timed_out <= 1'b0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == S_PRE) begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
                if (r_state == S_ARMED) begin
                    r_prev    <= adc_a_d;
                    r_p_valid <= 1'b1;
                    if (w_trig) begin
                        r_trig_addr  <= r_wr_ptr;
                        r_start_addr <= r_wr_ptr - r_pretrig;
                        r_post_rem   <= w_post_init;
                        r_timed_out  <= w_to_hit & ~r_force & ~w_edge_hit;
                    end
                end
                if (r_state == S_POST) begin
                    r_post_rem <= r_post_rem - 1'b1;
                end
            end
        end
    end

    // Sample RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= DATA_W'({adc_a_d, adc_b_d});
        end
    end

    // Trigger-relative registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[r_start_addr + rd_addr];
        end
    end

    assign ready_mcu = (r_state == S_DONE);
    assign busy      = w_busy;
    assign rd_data   = r_rd_data;
    assign trig_addr = r_trig_addr;
    assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture_buffer
//  Description : Self-checking bench for adc_capture_buffer; read results are
//                queued when rd_addr is driven and compared one clock later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger_mcu = 1'b0;
    logic [7:0]  adc_a_d = 8'd0;
    logic [7:0]  adc_b_d = 8'd0;
    logic [31:0] cfg = 32'd0;
    logic        ready_mcu;
    logic        busy;
    logic [11:0] rd_addr = 12'd0;
    logic [15:0] rd_data;
    logic [11:0] trig_addr;
    logic        timed_out;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mode = 0;   // 0: word = cyc[15:0], 1: A ramp up, 2: A ramp down
    logic [15:0] exp_q [$];
    string       tag_q [$];

    adc_capture_buffer #(.ADDR_W(12), .DATA_W(16), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .trigger_mcu(trigger_mcu),
        .adc_a_d(adc_a_d), .adc_b_d(adc_b_d), .cfg(cfg),
        .ready_mcu(ready_mcu), .busy(busy), .rd_addr(rd_addr),
        .rd_data(rd_data), .trig_addr(trig_addr), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // ADC stimulus changes on the falling edge, stable at every rising edge
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            case (mode)
                0: begin adc_a_d = 8'((cyc >> 8) & 255); adc_b_d = 8'(cyc & 255); end
                1: begin adc_a_d = 8'(cyc & 255);        adc_b_d = 8'hC3; end
                default: begin adc_a_d = 8'(255 - (cyc & 255)); adc_b_d = 8'hC3; end
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive a rising edge on trigger_mcu; the arm takes effect at the 3rd edge
    task automatic arm(input logic [31:0] c, input logic pre_busy, output int c0);
        cfg = c;
        trigger_mcu = 1'b1;
        c0 = cyc;
        tick();
        tick();
        chk("arm_pre_busy", busy, pre_busy);
        tick();
        chk("arm_busy", busy, 1);
        chk("arm_ready", ready_mcu, 0);
        trigger_mcu = 1'b0;
    endtask

    task automatic wait_ready(input int exp_n, input int bound, input string tag);
        int n = 3;
        while (!ready_mcu && n < bound) begin
            tick();
            n = n + 1;
        end
        chk({tag, "_ready"}, ready_mcu, 1);
        chk({tag, "_busy"}, busy, 0);
        if (exp_n > 0) chk({tag, "_latency"}, n, exp_n);
    endtask

    task automatic rd_chk(input int k, input logic [15:0] e, input string tag);
        rd_addr = 12'(k);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    initial begin
        int c0;
        int c1;
        int seen;

        // Reset
        tick();
        tick();
        chk("rst_ready", ready_mcu, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        // Force trigger, no pretrigger, no decimation: first write is the trigger
        mode = 0;
        arm(32'h0000_0200, 1'b0, c0);
        wait_ready(4099, 6000, "force");
        chk("force_trig_addr", trig_addr, 0);
        rd_chk(0,    16'(c0 + 4),    "force_rd0");
        rd_chk(1,    16'(c0 + 5),    "force_rd1");
        rd_chk(4095, 16'(c0 + 4099), "force_rd4095");

        // Rising level trigger at 0x80 with 100 pretrigger samples
        mode = 1;
        arm((32'd100 << 20) | 32'h80, 1'b0, c0);
        cfg = 32'h0000_0200;   // changes after arm must not matter
        wait_ready(0, 6000, "rise");
        rd_chk(100,  16'h80C3, "rise_rd100");
        rd_chk(99,   16'h7FC3, "rise_rd99");
        rd_chk(0,    16'h1CC3, "rise_rd0");
        rd_chk(4095, 16'h1BC3, "rise_rd4095");

        // Falling level trigger at 0x80 on a descending ramp
        mode = 2;
        arm((32'd100 << 20) | 32'h180, 1'b0, c0);
        wait_ready(0, 6000, "fall");
        rd_chk(100, 16'h80C3, "fall_rd100");
        rd_chk(99,  16'h81C3, "fall_rd99");
        rd_chk(101, 16'h7FC3, "fall_rd101");

        // Decimation by 4, re-armed mid-POST
        mode = 0;
        arm(32'h0000_0A00, 1'b0, c0);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            seen = seen + int'(ready_mcu);
        end
        chk("rearm_mid_ready", seen, 0);
        chk("rearm_mid_busy", busy, 1);
        arm(32'h0000_0A00, 1'b1, c1);
        wait_ready(16384, 20000, "decim");
        rd_chk(0,    16'(c1 + 4),            "decim_rd0");
        rd_chk(1,    16'(c1 + 8),            "decim_rd1");
        rd_chk(4095, 16'(c1 + 4 + 4 * 4095), "decim_rd4095");

        // Maximum pretrigger: only the trigger sample is post
        arm((32'd4095 << 20) | 32'h200, 1'b0, c0);
        wait_ready(4099, 6000, "maxpre");
        rd_chk(0,    16'(c0 + 4),    "maxpre_rd0");
        rd_chk(4094, 16'(c0 + 4098), "maxpre_rd4094");
        rd_chk(4095, 16'(c0 + 4099), "maxpre_rd4095");
        chk("maxpre_timed_out", timed_out, 0);

        // Reset in the middle of a capture
        arm(32'h0000_0200, 1'b0, c0);
        for (int i = 0; i < 100; i++) tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready_mcu, 0);
        chk("midrst_trig_addr", trig_addr, 0);
        rst = 1'b0;
        tick();
        chk("midrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Writer side of the ADC sample buffer that the SPI interface reads over mem_addr/mem_data.
- Captures {adc_a_d, adc_b_d} 16-bit samples into a circular 4096x16 RAM with pretrigger, level/edge trigger on channel A and decimation.
- Raises ready_mcu when a capture is complete.
- Presents a trigger-relative read port, so the SPI side reads logical index 0 as the oldest pretrigger sample.

Parameters:
ADDR_W, 12, buffer address width; depth = 2^ADDR_W
DATA_W, 16, sample word width; {ch A, ch B}
SYNC_STAGES, 2, synchroniser depth on trigger_mcu

Ports:
clk  input  1  system clock; all logic in this domain
rst  input  1  synchronous active-high reset
trigger_mcu  input  1  MCU arm request, asynchronous; rising edge arms a capture
adc_a_d  input  8  channel A sample (trigger source)
adc_b_d  input  8  channel B sample
cfg  input  32  adc_cfg word: [7:0] level, [8] slope (0 rising, 1 falling), [9] force, [13:10] decim log2, [19:14] reserved, [31:20] pretrig count
ready_mcu  output  1  capture complete, buffer stable
busy  output  1  capture in progress (PRE/ARMED/POST)
rd_addr  input  ADDR_W  logical read index from the SPI side
rd_data  output  DATA_W  sample at logical index; 1-cycle latency
trig_addr  output  ADDR_W  physical address of the trigger sample
timed_out  output  1  last capture was auto-triggered (optional feature)

Behaviour:
- Reset: state IDLE; ready_mcu=0, busy=0, trig_addr=0, timed_out=0, wr_ptr=0, start_addr=0, rd_data=0. RAM contents are not cleared.
- Arm: trigger_mcu passes through SYNC_STAGES flops. A rising-edge detect produces a 1-cycle arm pulse, 3 clk after the pin edge with SYNC_STAGES=2.
- Sample strobe: free-running decimation counter; strobe every 2^cfg[13:10] clk. The counter restarts on arm. At 0 every clk is a strobe.
- Writes: only on strobe in PRE/ARMED/POST. RAM[wr_ptr] <= {adc_a_d, adc_b_d}, then wr_ptr increments mod 2^ADDR_W.
- cfg is latched on arm (cfg_l). Later changes have no effect until the next arm.
- States:
  - IDLE: arm -> PRE (or ARMED if pretrig=0); pre_cnt=0.
  - PRE: on each write pre_cnt++. After pretrig writes -> ARMED.
  - ARMED: writes continue circularly. Trigger test runs on each strobe against the current sample a and the previous strobed sample p.
    - Rising trigger: p < level && a >= level.
    - Falling trigger: p > level && a <= level.
    - Force=1: trigger on the first ARMED strobe.
    - p is invalid on the first ARMED strobe, so no edge trigger fires there.
    - On trigger: trig_addr <= wr_ptr (trigger sample is written this strobe), post_cnt = 2^ADDR_W - pretrig, state -> POST.
  - POST: the trigger sample counts as the first post write. After post_cnt total writes -> DONE.
  - DONE: ready_mcu=1, busy=0, no writes. start_addr = trig_addr - pretrig mod 2^ADDR_W.
- busy=1 exactly in PRE/ARMED/POST. ready_mcu=1 only in DONE and drops in the cycle after an arm.
- Read: physical = start_addr + rd_addr mod 2^ADDR_W. rd_data is registered, 1 clk after rd_addr.
  - Reads are valid only in DONE.
  - In other states rd_data still returns RAM contents but is undefined relative to the trigger.
- Boundary cases:
  - Arm in any state, including mid-capture, restarts from a fresh capture with ready_mcu=0.
  - Arm coincident with a trigger strobe: arm wins.
  - pretrig max 4095 leaves post=1, i.e. the trigger sample only.
  - wr_ptr wrap at 4095->0 is seamless.
  - rst mid-capture returns to IDLE immediately.

Optional Feature:
CAPTURE_TIMEOUT_EN
- Defined: a 24-bit counter counts ARMED strobes. When it reaches 2^24-1 without a trigger, the block forces a trigger exactly as force=1 would and sets timed_out=1. timed_out clears on the next arm.
- Undefined: ARMED waits indefinitely; timed_out is tied 0 and no counter is built.

Test Plan:
- rst held 2 clk -> ready_mcu=0, busy=0, trig_addr=0, timed_out=0.
- cfg decim=0, force=1, pretrig=0; arm; ramp A=0,1,2... -> busy 4096 strobes; ready_mcu=1; rd_addr=0 returns A=value at trigger strobe; rd_addr=4095 returns that +4095 mod 256.
- cfg level=0x80, rising, pretrig=100, decim=0; A ramp 0x00..0xFF repeating -> trigger on sample 0x80 after PRE. rd_addr=100 yields A=0x80; rd_addr=99 yields 0x7F.
- Same with falling slope and A ramp down -> rd_addr=100 yields 0x80, rd_addr=99 yields 0x81.
- decim=2 with a ramp incrementing every clk -> consecutive buffer words differ by 4. Re-arm mid-POST -> ready_mcu stays 0 and a fresh capture completes.
- With CAPTURE_TIMEOUT_EN, level=0xFF, constant A=0x10 -> auto-trigger after 2^24-1 strobes; timed_out=1, ready_mcu=1.
